// File: rtl/serial_bit_source_pkg.sv
// Shared types and constants for the serial bit source that feeds the zero detector.
package serial_bit_source_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b1;
  localparam int   GAP_CNT_W          = 8;

  // Keeps the bit counter at least one bit wide for degenerate widths.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_bit_source_piso_shift_reg.sv
// Parallel-in/serial-out register. It holds the bits still to be sent after the one on x_out,
// so the head bit of a freshly loaded word is presented combinationally on the load cycle.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             serial
);

  logic [WIDTH-1:0] sr;

  generate
    if (MSB_FIRST) begin : g_msb
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sr <= '0;
        end else if (load) begin
          sr <= {d[WIDTH-2:0], 1'b0};
        end else if (shift) begin
          sr <= {sr[WIDTH-2:0], 1'b0};
        end
      end
      assign serial = load ? d[WIDTH-1] : sr[WIDTH-1];
    end else begin : g_lsb
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sr <= '0;
        end else if (load) begin
          sr <= {1'b0, d[WIDTH-1:1]};
        end else if (shift) begin
          sr <= {1'b0, sr[WIDTH-1:1]};
        end
      end
      assign serial = load ? d[0] : sr[0];
    end
  endgenerate

endmodule

// File: rtl/serial_bit_source.sv
// Serializes WIDTH-bit words onto x_out, one bit per clock, with an optional idle gap after
// each word. bit_valid and done let a checker align a downstream detector with the bits.
//
//  state   | meaning
//  S_IDLE  | x_out at IDLE_LEVEL, waiting for a load
//  S_SHIFT | word bit bit_cnt on x_out
//  S_GAP   | forced idle after a word, gap_cnt counts cycles
module serial_bit_source
  import serial_bit_source_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT,
  parameter int   GAP_CYCLES = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int                   CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);
  localparam bit                   HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [GAP_CNT_W-1:0] LAST_GAP = HAS_GAP ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [GAP_CNT_W-1:0]   gap_cnt;
  logic [CNT_W-1:0]       bit_cnt_inc;
  logic                   accept;
  logic                   shift_en;
  logic                   next_bit;

  assign accept      = load_valid & load_ready;
  assign shift_en    = (state == S_SHIFT) && (bit_cnt != LAST_BIT);
  assign bit_cnt_inc = bit_cnt + CNT_W'(1);

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clock  (clock),
    .reset  (reset),
    .load   (accept),
    .shift  (shift_en),
    .d      (data_in),
    .serial (next_bit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      x_out      <= IDLE_LEVEL;
      bit_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_SHIFT;
            bit_cnt    <= '0;
            x_out      <= next_bit;
            bit_valid  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            load_ready <= 1'b0;
          end
        end

        S_SHIFT: begin
          if (bit_cnt != LAST_BIT) begin
            bit_cnt    <= bit_cnt_inc;
            x_out      <= next_bit;
            done       <= (bit_cnt_inc == LAST_BIT);
            // Without a gap the last bit cycle can already take the next word.
            load_ready <= !HAS_GAP && (bit_cnt_inc == LAST_BIT);
          end else if (HAS_GAP) begin
            state      <= S_GAP;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            x_out      <= IDLE_LEVEL;
            bit_valid  <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b0;
          end else if (accept) begin
            bit_cnt    <= '0;
            x_out      <= next_bit;
            done       <= 1'b0;
            load_ready <= 1'b0;
          end else begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            x_out      <= IDLE_LEVEL;
            bit_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
          end
        end

        S_GAP: begin
          if (gap_cnt == LAST_GAP) begin
            state      <= S_IDLE;
            gap_cnt    <= '0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_CNT_W'(1);
          end
        end

        default: begin
          state      <= S_IDLE;
          bit_cnt    <= '0;
          gap_cnt    <= '0;
          x_out      <= IDLE_LEVEL;
          bit_valid  <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Directed bench for serial_bit_source: three instances cover no gap, a 3-cycle gap and LSB-first.
module tb_serial_bit_source;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [7:0] data0, data1, data2;
  logic lv0, lv1, lv2;
  logic lr0, lr1, lr2;
  logic x0, x1, x2;
  logic bv0, bv1, bv2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1), .GAP_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .data_in(data0), .load_valid(lv0), .load_ready(lr0),
    .x_out(x0), .bit_valid(bv0), .busy(busy0), .done(done0));

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1), .GAP_CYCLES(3)) dut1 (
    .clock(clock), .reset(reset), .data_in(data1), .load_valid(lv1), .load_ready(lr1),
    .x_out(x1), .bit_valid(bv1), .busy(busy1), .done(done1));

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .GAP_CYCLES(1)) dut2 (
    .clock(clock), .reset(reset), .data_in(data2), .load_valid(lv2), .load_ready(lr2),
    .x_out(x2), .bit_valid(bv2), .busy(busy2), .done(done2));

  // Mealy zero detector reference: y high when x is 0 and the previous x was 1.
  logic det_prev;
  logic y_out;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) det_prev <= 1'b0;
    else       det_prev <= x0;
  end
  assign y_out = ~x0 & det_prev;

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++; if (x0 !== 1'b1)    begin failures++; $display("FAIL reset_x0 got=%b exp=1", x0); end
    checks++; if (bv0 !== 1'b0)   begin failures++; $display("FAIL reset_bv0 got=%b exp=0", bv0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done0 got=%b exp=0", done0); end
    checks++; if (lr0 !== 1'b1)   begin failures++; $display("FAIL reset_lr0 got=%b exp=1", lr0); end
    checks++; if (x1 !== 1'b1 || x2 !== 1'b1) begin failures++; $display("FAIL reset_x12 got=%b%b exp=11", x1, x2); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_msb_word();
    logic [7:0] w;
    w = 8'hA5;
    checks++; if (lr0 !== 1'b1) begin failures++; $display("FAIL msb_ready_idle got=%b exp=1", lr0); end
    data0 = w; lv0 = 1'b1;
    @(negedge clock);
    lv0 = 1'b0; data0 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++; if (x0 !== w[7-i]) begin failures++; $display("FAIL msb_bit%0d got=%b exp=%b", i, x0, w[7-i]); end
      checks++; if (bv0 !== 1'b1 || busy0 !== 1'b1) begin failures++; $display("FAIL msb_valid%0d got=%b%b exp=11", i, bv0, busy0); end
      checks++; if (done0 !== (i == 7)) begin failures++; $display("FAIL msb_done%0d got=%b exp=%b", i, done0, (i == 7)); end
      checks++; if (lr0 !== (i == 7)) begin failures++; $display("FAIL msb_ready%0d got=%b exp=%b", i, lr0, (i == 7)); end
      if (i < 7) @(negedge clock);
    end
    @(negedge clock);
    checks++; if (x0 !== 1'b1 || bv0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || lr0 !== 1'b1) begin
      failures++; $display("FAIL msb_after got x=%b bv=%b busy=%b done=%b lr=%b exp 1 0 0 0 1", x0, bv0, busy0, done0, lr0);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_bits;
    exp_bits = 16'h0FF0;
    @(negedge clock);
    data0 = 8'h0F; lv0 = 1'b1;
    @(negedge clock);
    lv0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (x0 !== exp_bits[15-i]) begin failures++; $display("FAIL b2b_bit%0d got=%b exp=%b", i, x0, exp_bits[15-i]); end
      checks++; if (bv0 !== 1'b1) begin failures++; $display("FAIL b2b_valid%0d got=%b exp=1", i, bv0); end
      checks++; if (done0 !== (i == 7 || i == 15)) begin failures++; $display("FAIL b2b_done%0d got=%b exp=%b", i, done0, (i == 7 || i == 15)); end
      if (i == 7) begin
        checks++; if (lr0 !== 1'b1) begin failures++; $display("FAIL b2b_ready_done got=%b exp=1", lr0); end
        data0 = 8'hF0; lv0 = 1'b1;
      end
      if (i == 8) lv0 = 1'b0;
      if (i < 15) @(negedge clock);
    end
    @(negedge clock);
    checks++; if (bv0 !== 1'b0 || busy0 !== 1'b0 || x0 !== 1'b1) begin
      failures++; $display("FAIL b2b_after got bv=%b busy=%b x=%b exp 0 0 1", bv0, busy0, x0);
    end
  endtask

  task automatic test_gap();
    logic [20:0] ex, ebv, ebusy, elr, edone;
    ex    = {8'h3C, 4'b1111, 8'h81, 1'b1};
    ebv   = {8'hFF, 4'b0000, 8'hFF, 1'b0};
    ebusy = {8'hFF, 3'b111, 1'b0, 8'hFF, 1'b1};
    elr   = {8'h00, 3'b000, 1'b1, 8'h00, 1'b0};
    edone = {8'h01, 4'b0000, 8'h01, 1'b0};
    checks++; if (lr1 !== 1'b1) begin failures++; $display("FAIL gap_ready_idle got=%b exp=1", lr1); end
    data1 = 8'h3C; lv1 = 1'b1;
    @(negedge clock);
    data1 = 8'h81;
    for (int c = 0; c < 21; c++) begin
      checks++; if (x1 !== ex[20-c]) begin failures++; $display("FAIL gap_x_c%0d got=%b exp=%b", c + 1, x1, ex[20-c]); end
      checks++; if (bv1 !== ebv[20-c]) begin failures++; $display("FAIL gap_bv_c%0d got=%b exp=%b", c + 1, bv1, ebv[20-c]); end
      checks++; if (busy1 !== ebusy[20-c]) begin failures++; $display("FAIL gap_busy_c%0d got=%b exp=%b", c + 1, busy1, ebusy[20-c]); end
      checks++; if (lr1 !== elr[20-c]) begin failures++; $display("FAIL gap_ready_c%0d got=%b exp=%b", c + 1, lr1, elr[20-c]); end
      checks++; if (done1 !== edone[20-c]) begin failures++; $display("FAIL gap_done_c%0d got=%b exp=%b", c + 1, done1, edone[20-c]); end
      if (c == 12) lv1 = 1'b0;
      @(negedge clock);
    end
    repeat (2) @(negedge clock);
    checks++; if (busy1 !== 1'b0 || lr1 !== 1'b1 || bv1 !== 1'b0) begin
      failures++; $display("FAIL gap_end got busy=%b lr=%b bv=%b exp 0 1 0", busy1, lr1, bv1);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    w = 8'h03;
    data2 = w; lv2 = 1'b1;
    @(negedge clock);
    lv2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (x2 !== w[i]) begin failures++; $display("FAIL lsb_bit%0d got=%b exp=%b", i, x2, w[i]); end
      checks++; if (done2 !== (i == 7) || lr2 !== 1'b0) begin failures++; $display("FAIL lsb_ctl%0d got done=%b lr=%b exp %b 0", i, done2, lr2, (i == 7)); end
      @(negedge clock);
    end
    checks++; if (busy2 !== 1'b1 || bv2 !== 1'b0 || x2 !== 1'b1 || lr2 !== 1'b0) begin
      failures++; $display("FAIL lsb_gap got busy=%b bv=%b x=%b lr=%b exp 1 0 1 0", busy2, bv2, x2, lr2);
    end
    @(negedge clock);
    checks++; if (busy2 !== 1'b0 || lr2 !== 1'b1) begin
      failures++; $display("FAIL lsb_idle got busy=%b lr=%b exp 0 1", busy2, lr2);
    end
  endtask

  task automatic test_reset_mid_word();
    data0 = 8'h00; lv0 = 1'b1;
    @(negedge clock);
    lv0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (x0 !== 1'b0 || bv0 !== 1'b1) begin failures++; $display("FAIL midrst_bit%0d got x=%b bv=%b exp 0 1", i, x0, bv0); end
      @(negedge clock);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (x0 !== 1'b1 || bv0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      failures++; $display("FAIL midrst_now got x=%b bv=%b busy=%b done=%b exp 1 0 0 0", x0, bv0, busy0, done0);
    end
    data0 = 8'h55; lv0 = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      failures++; $display("FAIL midrst_noload got busy=%b done=%b exp 0 0", busy0, done0);
    end
    @(negedge clock);
    lv0 = 1'b0; reset = 1'b0;
    @(negedge clock);
    checks++; if (busy0 !== 1'b0 || x0 !== 1'b1 || lr0 !== 1'b1) begin
      failures++; $display("FAIL midrst_release got busy=%b x=%b lr=%b exp 0 1 1", busy0, x0, lr0);
    end
    data0 = 8'hFF; lv0 = 1'b1;
    @(negedge clock);
    lv0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (x0 !== 1'b1 || bv0 !== 1'b1) begin failures++; $display("FAIL midrst_ff%0d got x=%b bv=%b exp 1 1", i, x0, bv0); end
      checks++; if (done0 !== (i == 7)) begin failures++; $display("FAIL midrst_done%0d got=%b exp=%b", i, done0, (i == 7)); end
      @(negedge clock);
    end
    checks++; if (bv0 !== 1'b0) begin failures++; $display("FAIL midrst_after got bv=%b exp 0", bv0); end
  endtask

  task automatic test_detector_system();
    logic [7:0] w, ey;
    w  = 8'b1101_0011;
    ey = 8'b0010_1000;
    @(negedge clock);
    data0 = w; lv0 = 1'b1;
    @(negedge clock);
    lv0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (x0 !== w[7-i]) begin failures++; $display("FAIL sys_x%0d got=%b exp=%b", i, x0, w[7-i]); end
      checks++; if (y_out !== ey[7-i]) begin failures++; $display("FAIL sys_y%0d got=%b exp=%b", i, y_out, ey[7-i]); end
      @(negedge clock);
    end
    checks++; if (x0 !== 1'b1 || y_out !== 1'b0) begin
      failures++; $display("FAIL sys_after got x=%b y=%b exp 1 0", x0, y_out);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    data0 = 8'h00; data1 = 8'h00; data2 = 8'h00;
    lv0 = 1'b0; lv1 = 1'b0; lv2 = 1'b0;
    test_reset();
    test_msb_word();
    test_back_to_back();
    test_gap();
    test_lsb_first();
    test_reset_mid_word();
    test_detector_system();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
